// File: rtl/tron_player_mover.sv
// Tron light-cycle trajectory generator: turns direction buttons into a heading, advances one
// cell per game tick, and freezes on a dead flag from the collision checker or on a wall hit.
module tron_player_mover #(
    parameter int TICK_DIV  = 2500000,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119,
    parameter int X_START   = 20,
    parameter int Y_START   = 60,
    parameter int DIR_START = 0,
    parameter int WRAP      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dead,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [1:0] dir,
    output logic       moving,
    output logic       step,
    output logic       wall_hit
);
    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]    XM        = 10'(X_MAX);
    localparam logic [9:0]    YM        = 10'(Y_MAX);
    localparam logic [9:0]    XS        = 10'(X_START);
    localparam logic [9:0]    YS        = 10'(Y_START);
    localparam logic [1:0]    DS        = 2'(DIR_START);
    localparam bit            WRAP_EN   = (WRAP != 0);

    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_UP    = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_DOWN  = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] tick_cnt;
    logic [1:0]    pending;
    logic [3:0]    btn_prev;
    logic [3:0]    btn_now;
    logic [3:0]    btn_rise;
    logic          req_valid;
    logic [1:0]    req_dir;
    logic          start_ok;
    logic          tick;
    logic          at_edge;
    logic          wall;
    logic [9:0]    x_next;
    logic [9:0]    y_next;

    // Button vector ordered {up, down, left, right} so the priority chain reads top-down.
    assign btn_now  = {btn_up, btn_down, btn_left, btn_right};
    assign btn_rise = btn_now & ~btn_prev;
    assign start_ok = start && (state != RUN);
    assign tick     = (state == RUN) && (tick_cnt == TICK_LAST);
    assign wall     = tick && !dead && at_edge && !WRAP_EN;

    always_comb begin
        req_valid = 1'b1;
        req_dir   = dir;
        if (btn_rise[3])      req_dir = D_UP;
        else if (btn_rise[2]) req_dir = D_DOWN;
        else if (btn_rise[1]) req_dir = D_LEFT;
        else if (btn_rise[0]) req_dir = D_RIGHT;
        else                  req_valid = 1'b0;
    end

    // Candidate next cell in the pending heading; the wrapped value doubles as the WRAP=1 result.
    always_comb begin
        x_next  = x;
        y_next  = y;
        at_edge = 1'b0;
        case (pending)
            D_RIGHT: begin
                at_edge = (x == XM);
                x_next  = at_edge ? 10'd0 : x + 10'd1;
            end
            D_LEFT: begin
                at_edge = (x == 10'd0);
                x_next  = at_edge ? XM : x - 10'd1;
            end
            D_UP: begin
                at_edge = (y == 10'd0);
                y_next  = at_edge ? YM : y - 10'd1;
            end
            default: begin
                at_edge = (y == YM);
                y_next  = at_edge ? 10'd0 : y + 10'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (dead || wall) state_next = STOP;
            STOP:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        moving = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= XS;
            y        <= YS;
            dir      <= DS;
            pending  <= DS;
            step     <= 1'b0;
            wall_hit <= 1'b0;
            tick_cnt <= '0;
            btn_prev <= 4'd0;
        end else begin
            btn_prev <= btn_now;
            step     <= 1'b0;
            if (start_ok) begin
                x        <= XS;
                y        <= YS;
                dir      <= DS;
                pending  <= DS;
                wall_hit <= 1'b0;
                tick_cnt <= '0;
            end else if (state == RUN && !dead) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    dir <= pending;
                    if (wall) begin
                        wall_hit <= 1'b1;
                    end else begin
                        x    <= x_next;
                        y    <= y_next;
                        step <= 1'b1;
                    end
                end
                // A request landing on the tick cycle overwrites pending after it was consumed.
                if (req_valid && ((req_dir ^ dir) != 2'd2)) pending <= req_dir;
            end
        end
    end
endmodule
